// File: rtl/tt3_sweep_checker.sv
// Truth-table sweep checker for 3-input gate netlists: walks all 8 input vectors, samples the output, compares to EXPECTED.
// Optional macro TT3_SWEEP_STABILITY_CHECK_EN adds a one-cycle re-sample per vector and the `unstable` output.
module tt3_sweep_checker #(
    parameter logic [7:0] EXPECTED      = 8'h7E,
    parameter int         SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       stim_in1,
    output logic       stim_in2,
    output logic       stim_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed,
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
    output logic [7:0] unstable,
`endif
    output logic [7:0] mismatch_mask
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // SETTLE| vector r_idx applied, counting settle cycles (plus CHECK sub-phase when enabled)
    // DONE  | one-cycle completion, done pulse high
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

    localparam int         SC_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [7:0] LP_LAST = 8'(SC_EFF - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_idx;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_observed;
    logic [7:0] r_mask;

`ifdef TT3_SWEEP_STABILITY_CHECK_EN
    logic       r_check;
    logic [7:0] r_unstable;
    logic [7:0] w_unst_next;

    always_comb begin
        w_unst_next = r_unstable;
        if (dut_out != r_observed[r_idx]) w_unst_next[r_idx] = 1'b1;
    end
`else
    logic [7:0] w_obs_next;

    // Include the row being sampled this edge so row 7 is part of the final compare.
    always_comb begin
        w_obs_next        = r_observed;
        w_obs_next[r_idx] = dut_out;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_idx      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_observed <= 8'h00;
            r_mask     <= 8'h00;
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
            r_check    <= 1'b0;
            r_unstable <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_SETTLE;
                        r_idx      <= 3'd0;
                        r_cnt      <= 8'd0;
                        r_busy     <= 1'b1;
                        r_observed <= 8'h00;
                        r_mask     <= 8'h00;
                        r_pass     <= 1'b0;
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
                        r_check    <= 1'b0;
                        r_unstable <= 8'h00;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
                    if (r_check) begin
                        r_check    <= 1'b0;
                        r_unstable <= w_unst_next;
                        r_cnt      <= 8'd0;
                        if (r_idx != 3'd7) begin
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_state <= S_DONE;
                            r_idx   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_mask  <= r_observed ^ EXPECTED;
                            r_pass  <= ((r_observed ^ EXPECTED) == 8'h00) && (w_unst_next == 8'h00);
                        end
                    end else if (r_cnt == LP_LAST) begin
                        r_observed[r_idx] <= dut_out;
                        r_check           <= 1'b1;
                        r_cnt             <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`else
                    if (r_cnt == LP_LAST) begin
                        r_observed <= w_obs_next;
                        r_cnt      <= 8'd0;
                        if (r_idx != 3'd7) begin
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_state <= S_DONE;
                            r_idx   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_mask  <= w_obs_next ^ EXPECTED;
                            r_pass  <= ((w_obs_next ^ EXPECTED) == 8'h00);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stim_in1      = r_idx[2];
    assign stim_in2      = r_idx[1];
    assign stim_in3      = r_idx[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign observed      = r_observed;
    assign mismatch_mask = r_mask;
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
    assign unstable      = r_unstable;
`endif

endmodule

// File: tb/tb_tt3_sweep_checker.sv
// Directed bench for tt3_sweep_checker: golden 0x7E netlist model, stuck outputs, held start, mid-sweep reset.
// Covers TT3_SWEEP_STABILITY_CHECK_EN when that macro is defined.
module tb_tt3_sweep_checker;
    localparam logic [7:0] EXP = 8'h7E;
    localparam int SC = 4;
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
    localparam int PV = SC + 1;
`else
    localparam int PV = SC;
`endif
    localparam int HOLD = 8 * PV + 8;

    logic clk = 1'b0;
    logic rst, start, dut_out;
    logic stim_in1, stim_in2, stim_in3, busy, done, pass;
    logic [7:0] observed, mismatch_mask;
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
    logic [7:0] unstable;
`endif
    int   mode;
    logic inv;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic w_gold;

    always #5 clk = ~clk;

    // Reference 0x7E netlist: output low only for 000 and 111.
    assign w_gold  = ~((stim_in1 & stim_in2 & stim_in3) | (~stim_in1 & ~stim_in2 & ~stim_in3));
    assign dut_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (w_gold ^ inv);

    tt3_sweep_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(SC)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .stim_in1(stim_in1), .stim_in2(stim_in2), .stim_in3(stim_in3),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .observed(observed),
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
        .unstable(unstable),
`endif
        .mismatch_mask(mismatch_mask)
    );

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, o, e);
        end
    endtask

    task automatic run_sweep(input string tag, input int m, input int inv_n,
                             input logic [7:0] e_obs, input logic [7:0] e_mask,
                             input logic e_pass, input logic [7:0] e_unst);
        logic [2:0] v;
        mode = m;
        inv  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 8 * PV; n++) begin
            @(negedge clk);
            start = 1'b0;
            inv   = (n == inv_n);
            v     = 3'(n / PV);
            chk({tag, "_walk"}, {3'b0, busy, done, stim_in1, stim_in2, stim_in3},
                {3'b0, 1'b1, 1'b0, v});
            @(posedge clk);
        end
        @(negedge clk);
        inv = 1'b0;
        chk({tag, "_done"}, {3'b0, busy, done, stim_in1, stim_in2, stim_in3}, 8'b000_01_000);
        chk({tag, "_obs"}, observed, e_obs);
        chk({tag, "_mask"}, mismatch_mask, e_mask);
        chk({tag, "_pass"}, {7'b0, pass}, {7'b0, e_pass});
`ifdef TT3_SWEEP_STABILITY_CHECK_EN
        chk({tag, "_unstable"}, unstable, e_unst);
`else
        if (e_unst != 8'h00) $display("note: %s expects instability only with the stability check", tag);
`endif
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold"}, {5'b0, busy, done, pass}, {5'b0, 1'b0, 1'b0, e_pass});
        chk({tag, "_hold_obs"}, observed, e_obs);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        inv   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {3'b0, busy, done, stim_in1, stim_in2, stim_in3}, 8'h00);
        chk("reset_pass", {7'b0, pass}, 8'h00);
        chk("reset_obs", observed, 8'h00);
        chk("reset_mask", mismatch_mask, 8'h00);
        rst = 1'b0;

        run_sweep("golden", 0, -1, 8'h7E, 8'h00, 1'b1, 8'h00);
        run_sweep("tie0", 1, -1, 8'h00, 8'h7E, 1'b0, 8'h00);
        run_sweep("tie1", 2, -1, 8'hFF, 8'h81, 1'b0, 8'h00);

        // start held high: restart from DONE, ignored while busy
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 16 * PV + 1; n++) begin
            @(negedge clk);
            if (n == HOLD - 1) start = 1'b0;
            chk("hold_busy_done", {6'b0, busy, done},
                {6'b0, (n < 8 * PV) || (n > 8 * PV && n < 16 * PV + 1),
                 (n == 8 * PV) || (n == 16 * PV + 1)});
            if (n == 8 * PV) begin
                chk("hold_first_obs", observed, 8'h7E);
                chk("hold_first_pass", {7'b0, pass}, 8'h01);
            end
            if (n == 8 * PV + 1) chk("hold_restart_clear", observed, 8'h00);
            if (n < 16 * PV + 1) @(posedge clk);
        end
        chk("hold_second_obs", observed, 8'h7E);
        chk("hold_second_mask", mismatch_mask, 8'h00);
        chk("hold_second_pass", {7'b0, pass}, 8'h01);
        @(posedge clk);
        @(negedge clk);

        // reset at edge 10 of a sweep
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctl", {3'b0, busy, done, stim_in1, stim_in2, stim_in3}, 8'h00);
        chk("midrst_pass", {7'b0, pass}, 8'h00);
        chk("midrst_obs", observed, 8'h00);
        chk("midrst_mask", mismatch_mask, 8'h00);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_idle", {6'b0, busy, done}, 8'h00);
        end
        run_sweep("after_rst", 0, -1, 8'h7E, 8'h00, 1'b1, 8'h00);

`ifdef TT3_SWEEP_STABILITY_CHECK_EN
        run_sweep("glitch3", 0, 3 * PV + SC, 8'h7E, 8'h00, 1'b0, 8'h08);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
